sync_fifo_ctrl: RTL and testbench

- Single-clock FIFO: pointer/flag control plus an inferred dual-port RAM, with parametrised width and depth.
- Successor to the fixed 256x16 BRAM-backed memory wrapper.
- Adds full/empty generation, programmable almost-full/almost-empty, occupancy count, registered read with valid strobe, and optional sticky error flags.
- Used as the intra-domain buffer between streaming stages.

---
 rtl/sync_fifo_ctrl.sv | 118 +++++++++++
 tb/tb_sync_fifo_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointer/flag control with an inferred dual-port RAM and registered read.
// Optional sticky overflow/underflow outputs are enabled with the FIFO_ERR_FLAG_EN macro.
module sync_fifo_ctrl #(
    parameter int unsigned FIFO_DEPTH_Bit = 8,
    parameter int unsigned FIFO_WIDTH_Bit = 16,
    parameter int unsigned AFULL_THRESH   = (2 ** FIFO_DEPTH_Bit) - 4,
    parameter int unsigned AEMPTY_THRESH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [FIFO_WIDTH_Bit-1:0] wr_data,
    output logic                      wr_full,
    input  logic                      rd_en,
    output logic [FIFO_WIDTH_Bit-1:0] rd_data,
    output logic                      rd_valid,
    output logic                      rd_empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [FIFO_DEPTH_Bit:0]   data_count
`ifdef FIFO_ERR_FLAG_EN
    ,
    output logic                      overflow,
    output logic                      underflow
`endif
);

    localparam int unsigned AW    = FIFO_DEPTH_Bit;
    localparam int unsigned DW    = FIFO_WIDTH_Bit;
    localparam int unsigned CW    = FIFO_DEPTH_Bit + 1;
    localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_Bit;

    localparam logic [CW-1:0] AFULL_LVL  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_LVL = CW'(AEMPTY_THRESH);

    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] wr_ptr_nxt;
    logic [CW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count_nxt;
    logic          wr_ok;
    logic          rd_ok;

    logic [DW-1:0] mem [DEPTH];

    // Accept decisions use the registered (pre-edge) flags; next-state pointers and count follow.
    always_comb begin
        wr_ok      = wr_en && !wr_full;
        rd_ok      = rd_en && !rd_empty;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = data_count;
        if (wr_ok) begin
            wr_ptr_nxt = wr_ptr + CW'(1);
        end
        if (rd_ok) begin
            rd_ptr_nxt = rd_ptr + CW'(1);
        end
        if (wr_ok && !rd_ok) begin
            count_nxt = data_count + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_nxt = data_count - CW'(1);
        end
    end

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Flags are derived from next-state pointers/count so they line up with data_count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            data_count   <= '0;
            rd_empty     <= 1'b1;
            wr_full      <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            data_count   <= count_nxt;
            rd_empty     <= (wr_ptr_nxt == rd_ptr_nxt);
            wr_full      <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                            (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
            almost_full  <= (count_nxt >= AFULL_LVL);
            almost_empty <= (count_nxt <= AEMPTY_LVL);
            rd_valid     <= rd_ok;
            if (rd_ok) begin
                rd_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

`ifdef FIFO_ERR_FLAG_EN
    // Sticky error flags record any access attempted against a full or empty FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && wr_full) begin
                overflow <= 1'b1;
            end
            if (rd_en && rd_empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: queue-based reference model compared every cycle,
// plus literal expectations at key points of the directed sequence.
module tb_sync_fifo_ctrl;

    localparam int unsigned AW     = 8;
    localparam int unsigned DW     = 16;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned AFULL  = 252;
    localparam int unsigned AEMPTY = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          wr_full;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   data_count;
`ifdef FIFO_ERR_FLAG_EN
    logic          overflow;
    logic          underflow;
`endif

    int errors = 0;
    int checks = 0;

    sync_fifo_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_full      (wr_full),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_empty     (rd_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .data_count   (data_count)
`ifdef FIFO_ERR_FLAG_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored words.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_data  = '0;
    logic          m_valid = 1'b0;
    logic          m_ovf   = 1'b0;
    logic          m_unf   = 1'b0;

    always @(posedge clk or posedge rst) begin
        int n;
        if (rst) begin
            q.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            n = q.size();
            if (wr_en && n == int'(DEPTH)) m_ovf = 1'b1;
            if (rd_en && n == 0)           m_unf = 1'b1;
            m_valid = rd_en && (n > 0);
            if (m_valid) m_data = q.pop_front();
            if (wr_en && n < int'(DEPTH)) q.push_back(wr_data);
        end
        #1;
        n = q.size();
        chk("data_count",   32'(data_count),   32'(n));
        chk("rd_empty",     32'(rd_empty),     32'(n == 0));
        chk("wr_full",      32'(wr_full),      32'(n == int'(DEPTH)));
        chk("almost_full",  32'(almost_full),  32'(n >= int'(AFULL)));
        chk("almost_empty", 32'(almost_empty), 32'(n <= int'(AEMPTY)));
        chk("rd_valid",     32'(rd_valid),     32'(m_valid));
        chk("rd_data",      32'(rd_data),      32'(m_data));
`ifdef FIFO_ERR_FLAG_EN
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_unf));
`endif
    end

    task automatic cyc(input logic we, input logic [DW-1:0] wd, input logic re);
        @(negedge clk);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
    endtask

    initial begin
        // Reset then idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) cyc(1'b0, '0, 1'b0);
        chk("lit_reset_empty",  32'(rd_empty),     32'd1);
        chk("lit_reset_full",   32'(wr_full),      32'd0);
        chk("lit_reset_count",  32'(data_count),   32'd0);
        chk("lit_reset_aempty", 32'(almost_empty), 32'd1);
        chk("lit_reset_valid",  32'(rd_valid),     32'd0);

        // Fill to full, then one dropped write
        for (int i = 1; i <= 256; i++) cyc(1'b1, DW'(i), 1'b0);
        cyc(1'b1, 16'hDEAD, 1'b0);
        cyc(1'b0, '0, 1'b0);
        chk("lit_fill_count", 32'(data_count),  32'd256);
        chk("lit_fill_full",  32'(wr_full),     32'd1);
        chk("lit_fill_afull", 32'(almost_full), 32'd1);

        // Drain all, then one read on empty
        for (int i = 0; i < 256; i++) cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);
        chk("lit_drain_last",  32'(rd_data),    32'h0100);
        chk("lit_drain_valid", 32'(rd_valid),   32'd1);
        chk("lit_drain_empty", 32'(rd_empty),   32'd1);
        cyc(1'b0, '0, 1'b0);
        chk("lit_extra_valid", 32'(rd_valid),   32'd0);
        chk("lit_extra_hold",  32'(rd_data),    32'h0100);
        chk("lit_extra_count", 32'(data_count), 32'd0);

        // Full with simultaneous write and read
        for (int i = 0; i < 256; i++) cyc(1'b1, DW'(16'h1000 + i), 1'b0);
        cyc(1'b1, 16'hBEEF, 1'b1);
        cyc(1'b0, '0, 1'b0);
        chk("lit_fullrw_count", 32'(data_count), 32'd255);
        chk("lit_fullrw_data",  32'(rd_data),    32'h1000);
        chk("lit_fullrw_valid", 32'(rd_valid),   32'd1);
        chk("lit_fullrw_full",  32'(wr_full),    32'd0);
        for (int i = 0; i < 255; i++) cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0);
        chk("lit_fullrw_tail", 32'(rd_data), 32'h10FF);

        // Streaming from empty: pointers wrap more than twice
        for (int i = 0; i < 600; i++) cyc(1'b1, DW'(16'h2000 + i), 1'b1);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0);
        chk("lit_stream_last",  32'(rd_data),    32'h2257);
        chk("lit_stream_count", 32'(data_count), 32'd0);

        // Reset in the middle of a burst
        for (int i = 0; i < 100; i++) cyc(1'b1, DW'(16'h3000 + i), 1'b0);
        cyc(1'b1, 16'h3100, 1'b1);
        cyc(1'b1, 16'h3101, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("lit_rst_count", 32'(data_count), 32'd0);
        chk("lit_rst_valid", 32'(rd_valid),   32'd0);
        chk("lit_rst_empty", 32'(rd_empty),   32'd1);
        chk("lit_rst_data",  32'(rd_data),    32'd0);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 16'h4444, 1'b0);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);
        chk("lit_post_rst_data",  32'(rd_data),  32'h4444);
        chk("lit_post_rst_valid", 32'(rd_valid), 32'd1);
        cyc(1'b0, '0, 1'b0);
        chk("lit_post_rst_only", 32'(rd_valid),   32'd0);
        chk("lit_post_rst_cnt",  32'(data_count), 32'd0);
        repeat (3) cyc(1'b0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
